// File: rtl/dct_mac_if.sv
// Frame-in / coefficient-out stream bundle for dct_mac.
// master = upstream/downstream environment, slave = the DCT engine.
interface dct_mac_if #(
    parameter int NUM_FILTERS = 32,
    parameter int DATA_WIDTH  = 16
);
    logic signed [DATA_WIDTH-1:0] log_data_in [NUM_FILTERS];
    logic                         log_valid_in;
    logic                         log_ready_out;
    logic signed [DATA_WIDTH-1:0] dct_data_out;
    logic                         dct_valid_out;
    logic                         dct_ready_in;
    logic                         dct_last_out;

    modport master (
        output log_data_in, log_valid_in, dct_ready_in,
        input  log_ready_out, dct_data_out, dct_valid_out, dct_last_out
    );

    modport slave (
        input  log_data_in, log_valid_in, dct_ready_in,
        output log_ready_out, dct_data_out, dct_valid_out, dct_last_out
    );
endinterface

// File: rtl/dct_mac.sv
// Direct multiply-accumulate DCT-II: one frame of log-mel energies in,
// N_DCT saturated cepstral coefficients out, one MAC per cycle.
module dct_mac #(
    parameter int NUM_FILTERS = 32,
    parameter int N_DCT       = 13,
    parameter int DATA_WIDTH  = 16,
    parameter int COEF_WIDTH  = 16,
    parameter int OUT_SHIFT   = 0,
    parameter int SKIP_C0     = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    dct_mac_if.slave    bus
);
    localparam int IW = $clog2(NUM_FILTERS);
    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam int AW = PW + IW;
    localparam int SH = COEF_WIDTH - 1 + OUT_SHIFT;

    localparam logic [IW-1:0] N_LAST  = IW'(NUM_FILTERS - 1);
    localparam logic [IW-1:0] K_FIRST = IW'(SKIP_C0);
    localparam logic [IW-1:0] K_LAST  = IW'(SKIP_C0 + N_DCT - 1);

    localparam longint SAT_MAX_L = (longint'(1) << (DATA_WIDTH - 1)) - 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(SAT_MAX_L);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-SAT_MAX_L - 1);

    function automatic int cos_coef(input int k, input int n);
        real ang;
        real v;
        ang = 3.14159265358979323846 * real'(k * (2 * n + 1)) / real'(2 * NUM_FILTERS);
        v   = real'((longint'(1) << (COEF_WIDTH - 1)) - 1) * $cos(ang);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    logic signed [COEF_WIDTH-1:0] coef_tbl [NUM_FILTERS][NUM_FILTERS];

    for (genvar gk = 0; gk < NUM_FILTERS; gk++) begin : g_k
        for (genvar gn = 0; gn < NUM_FILTERS; gn++) begin : g_n
            localparam int CV = cos_coef(gk, gn);
            assign coef_tbl[gk][gn] = COEF_WIDTH'(CV);
        end
    end

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT} state_t;

    state_t                       state_q;
    logic [IW-1:0]                k_q;
    logic [IW-1:0]                n_q;
    logic signed [AW-1:0]         acc_q;
    logic signed [DATA_WIDTH-1:0] frame_q [NUM_FILTERS];
    logic signed [DATA_WIDTH-1:0] data_q;
    logic                         valid_q;
    logic                         last_q;

    logic signed [PW-1:0]         prod_d;
    logic signed [AW-1:0]         acc_d;
    logic signed [AW-1:0]         scaled_d;
    logic signed [DATA_WIDTH-1:0] res_d;

    always_comb begin
        prod_d   = PW'(frame_q[n_q]) * PW'(coef_tbl[k_q][n_q]);
        acc_d    = acc_q + AW'(prod_d);
        scaled_d = acc_d >>> SH;
        if (scaled_d > SAT_MAX) begin
            res_d = DATA_WIDTH'(SAT_MAX);
        end else if (scaled_d < SAT_MIN) begin
            res_d = DATA_WIDTH'(SAT_MIN);
        end else begin
            res_d = DATA_WIDTH'(scaled_d);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            frame_q <= '{default: '0};
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.log_valid_in) begin
                        frame_q <= bus.log_data_in;
                        k_q     <= K_FIRST;
                        n_q     <= '0;
                        acc_q   <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    // The final product is folded straight into the output register.
                    if (n_q == N_LAST) begin
                        data_q  <= res_d;
                        valid_q <= 1'b1;
                        last_q  <= (k_q == K_LAST);
                        acc_q   <= acc_d;
                        n_q     <= '0;
                        state_q <= S_EMIT;
                    end else begin
                        acc_q <= acc_d;
                        n_q   <= n_q + IW'(1);
                    end
                end
                S_EMIT: begin
                    if (bus.dct_ready_in) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            k_q     <= k_q + IW'(1);
                            n_q     <= '0;
                            acc_q   <= '0;
                            state_q <= S_MAC;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.log_ready_out = (state_q == S_IDLE);
    assign bus.dct_data_out  = data_q;
    assign bus.dct_valid_out = valid_q;
    assign bus.dct_last_out  = last_q;
endmodule

// File: tb/tb_dct_mac.sv
// Directed + randomized bench for dct_mac; two instances (c0 kept / c0 dropped)
// run in lockstep against a floor-division reference model.
module tb_dct_mac;
    localparam int NF = 32;
    localparam int ND = 13;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int OS = 0;

    typedef logic signed [DW-1:0] frame_t [NF];

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    frame_t x_drv;
    frame_t x_cap;
    logic   valid_drv = 1'b0;
    logic   ready_drv = 1'b1;

    int     n_total = 0;
    int     n_pass  = 0;
    longint got_a [ND];
    longint got_b [ND];
    longint ref_a [ND];

    always #5 clk = ~clk;

    dct_mac_if #(.NUM_FILTERS(NF), .DATA_WIDTH(DW)) ifa ();
    dct_mac_if #(.NUM_FILTERS(NF), .DATA_WIDTH(DW)) ifb ();

    assign ifa.log_data_in  = x_drv;
    assign ifa.log_valid_in = valid_drv;
    assign ifa.dct_ready_in = ready_drv;
    assign ifb.log_data_in  = x_drv;
    assign ifb.log_valid_in = valid_drv;
    assign ifb.dct_ready_in = ready_drv;

    dct_mac #(.NUM_FILTERS(NF), .N_DCT(ND), .DATA_WIDTH(DW), .COEF_WIDTH(CW),
              .OUT_SHIFT(OS), .SKIP_C0(0)) dut (
        .clk_in(clk), .rst_in(rst), .bus(ifa));

    dct_mac #(.NUM_FILTERS(NF), .N_DCT(ND), .DATA_WIDTH(DW), .COEF_WIDTH(CW),
              .OUT_SHIFT(OS), .SKIP_C0(1)) dut_s (
        .clk_in(clk), .rst_in(rst), .bus(ifb));

    function automatic longint coef_ref(input int k, input int n);
        real c;
        c = ((2.0 ** (CW - 1)) - 1.0) * $cos(3.14159265358979323846 * k * (2 * n + 1) / (2.0 * NF));
        return longint'($floor(c + 0.5));
    endfunction

    function automatic longint dct_ref(input frame_t x, input int k);
        longint s, d, q, hi, lo;
        s = 0;
        for (int n = 0; n < NF; n++) s += longint'(x[n]) * coef_ref(k, n);
        d = longint'(1) << (CW - 1 + OS);
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -hi - 1;
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // rmode: 1 = random backpressure; pulse: 1 = spurious valid/data while busy;
    // abort_k >= 0: return 10 cycles into the MAC of coefficient abort_k.
    task automatic run_frame(input string name, input int rmode, input int pulse, input int abort_k);
        int     w;
        int     idx;
        int     beats [2];
        int     next_exp [2];
        bit     seen [2];
        bit     stall_prev [2];
        logic signed [DW-1:0] prev_d [2];
        logic   s_v [2];
        logic   s_l [2];
        logic signed [DW-1:0] s_d [2];
        bit     busy_rdy;
        bit     stray_last;
        w = 0;
        @(negedge clk);
        while (!(ifa.log_ready_out && ifb.log_ready_out) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("%s idle_ready", name), longint'(ifa.log_ready_out & ifb.log_ready_out), 1);
        if (!(ifa.log_ready_out && ifb.log_ready_out)) return;
        valid_drv = 1'b1;
        ready_drv = 1'b1;
        x_cap     = x_drv;
        @(negedge clk);
        valid_drv = 1'b0;
        for (int n = 0; n < NF; n++) x_drv[n] = DW'($urandom);
        idx = 0;
        busy_rdy = 1'b0;
        stray_last = 1'b0;
        for (int d = 0; d < 2; d++) begin
            beats[d] = 0; next_exp[d] = NF; seen[d] = 1'b0; stall_prev[d] = 1'b0; prev_d[d] = '0;
        end
        while (!(beats[0] == ND && beats[1] == ND) && idx < 4000) begin
            s_v[0] = ifa.dct_valid_out; s_l[0] = ifa.dct_last_out; s_d[0] = ifa.dct_data_out;
            s_v[1] = ifb.dct_valid_out; s_l[1] = ifb.dct_last_out; s_d[1] = ifb.dct_data_out;
            if (ifa.log_ready_out || ifb.log_ready_out) busy_rdy = 1'b1;
            if (abort_k >= 0 && beats[0] == abort_k && idx >= next_exp[0] - (NF + 1) + 10) begin
                ready_drv = 1'b1;
                return;
            end
            for (int d = 0; d < 2; d++) begin
                if (s_l[d] && !s_v[d]) stray_last = 1'b1;
                if (stall_prev[d])
                    chk($sformatf("%s d%0d stall_hold beat%0d", name, d, beats[d]),
                        longint'(s_v[d] && (s_d[d] == prev_d[d])), 1);
                if (s_v[d] && !seen[d] && beats[d] < ND) begin
                    seen[d] = 1'b1;
                    chk($sformatf("%s d%0d latency beat%0d", name, d, beats[d]), idx, next_exp[d]);
                    chk($sformatf("%s d%0d data beat%0d", name, d, beats[d]), s_d[d],
                        dct_ref(x_cap, beats[d] + d));
                    chk($sformatf("%s d%0d last beat%0d", name, d, beats[d]), longint'(s_l[d]),
                        longint'(beats[d] == ND - 1));
                    if (d == 0) got_a[beats[d]] = s_d[d];
                    else        got_b[beats[d]] = s_d[d];
                end
            end
            ready_drv = (rmode != 0) ? ($urandom_range(2) != 0) : 1'b1;
            for (int d = 0; d < 2; d++) begin
                stall_prev[d] = 1'b0;
                if (s_v[d] && ready_drv) begin
                    seen[d] = 1'b0;
                    beats[d]++;
                    next_exp[d] = idx + NF + 1;
                end else if (s_v[d]) begin
                    stall_prev[d] = 1'b1;
                    prev_d[d] = s_d[d];
                end
            end
            if (pulse != 0) begin
                valid_drv = ($urandom_range(3) == 0);
                x_drv[$urandom_range(NF - 1)] = DW'($urandom);
            end
            @(negedge clk);
            idx++;
        end
        valid_drv = 1'b0;
        ready_drv = 1'b1;
        chk($sformatf("%s frame_complete", name), longint'(beats[0] == ND && beats[1] == ND), 1);
        chk($sformatf("%s ready_after_last", name), longint'(ifa.log_ready_out & ifb.log_ready_out), 1);
        chk($sformatf("%s ready_low_while_busy", name), longint'(busy_rdy), 0);
        chk($sformatf("%s last_only_with_valid", name), longint'(stray_last), 0);
    endtask

    initial begin
        bit saw_valid;
        x_drv = '{default: '0};
        repeat (3) @(negedge clk);
        chk("reset_ready", longint'(ifa.log_ready_out), 1);
        chk("reset_valid", longint'(ifa.dct_valid_out | ifb.dct_valid_out), 0);
        chk("reset_data", ifa.dct_data_out, 0);
        chk("reset_last", longint'(ifa.dct_last_out | ifb.dct_last_out), 0);
        rst = 1'b0;

        saw_valid = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (ifa.dct_valid_out || ifb.dct_valid_out) saw_valid = 1'b1;
        end
        chk("idle_no_output", longint'(saw_valid), 0);

        for (int n = 0; n < NF; n++) x_drv[n] = 16'sd100;
        run_frame("const", 0, 0, -1);
        chk("const_c0", got_a[0], 3199);
        for (int k = 1; k < ND; k++)
            chk($sformatf("const_c%0d_small", k), longint'(got_a[k] == 0 || got_a[k] == -1), 1);

        x_drv = '{default: '0};
        x_drv[0] = 16'sd1000;
        run_frame("impulse", 0, 0, -1);
        chk("impulse_c0", got_a[0], 999);
        chk("impulse_skip_first", got_b[0], (1000 * coef_ref(1, 0)) >>> 15);

        for (int n = 0; n < NF; n++) x_drv[n] = 16'sd32767;
        run_frame("sat_pos", 0, 0, -1);
        chk("sat_pos_c0", got_a[0], 32767);

        for (int n = 0; n < NF; n++) x_drv[n] = -16'sd32768;
        run_frame("sat_neg", 0, 0, -1);
        chk("sat_neg_c0", got_a[0], -32768);

        for (int n = 0; n < NF; n++) x_drv[n] = DW'($urandom);
        x_cap = x_drv;
        run_frame("rand_ready1", 0, 0, -1);
        ref_a = got_a;
        x_drv = x_cap;
        run_frame("rand_bp", 1, 1, -1);
        for (int k = 0; k < ND; k++)
            chk($sformatf("bp_match_beat%0d", k), got_a[k], ref_a[k]);

        for (int n = 0; n < NF; n++) x_drv[n] = DW'($urandom_range(4000)) - 16'sd2000;
        run_frame("abort", 0, 0, 5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", longint'(ifa.dct_valid_out | ifb.dct_valid_out), 0);
        chk("async_rst_data", ifa.dct_data_out, 0);
        chk("async_rst_ready", longint'(ifa.log_ready_out & ifb.log_ready_out), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_no_output", longint'(ifa.dct_valid_out | ifb.dct_valid_out), 0);
        for (int n = 0; n < NF; n++) x_drv[n] = DW'($urandom);
        run_frame("after_reset", 0, 0, -1);

        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < NF; n++) x_drv[n] = DW'($urandom);
            run_frame($sformatf("rand%0d", f), 1, 1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
